// File: rtl/sha3_absorb_pad_if.sv
// Stream-in / block-out bundle for the SHA-3 absorb and pad stage.
// slave  = the absorb stage's view, master = the upstream and core side.
interface sha3_absorb_pad_if #(
   parameter int DATA_WIDTH = 16
);
   // message stream
   logic [DATA_WIDTH-1:0]   S_TDATA;
   logic [DATA_WIDTH/8-1:0] S_TKEEP;
   logic                    S_TLAST;
   logic                    S_TVALID;
   logic                    S_TREADY;
   logic [1:0]              S_TID;
   // block to Keccak core
   logic [1599:0]           Blk;
   logic [1:0]              Blk_tid;
   logic                    Blk_first;
   logic                    Blk_last;
   logic                    Blk_valid;
   logic                    Blk_ready;

   modport slave (
      input  S_TDATA, S_TKEEP, S_TLAST, S_TVALID, S_TID,
      output S_TREADY,
      output Blk, Blk_tid, Blk_first, Blk_last, Blk_valid,
      input  Blk_ready
   );

   modport master (
      output S_TDATA, S_TKEEP, S_TLAST, S_TVALID, S_TID,
      input  S_TREADY,
      input  Blk, Blk_tid, Blk_first, Blk_last, Blk_valid,
      output Blk_ready
   );
endinterface

// File: rtl/sha3_absorb_pad.sv
// SHA-3 input stage: packs stream bytes into rate-sized blocks, appends the
// 0x06..0x80 padding and presents 1600-bit blocks to the Keccak core.
module sha3_absorb_pad #(
   parameter int DATA_WIDTH = 16
) (
   input  logic             ACLK,
   input  logic             ARESET,
   sha3_absorb_pad_if.slave bus
);
   localparam int NB = DATA_WIDTH / 8;

   localparam logic [1:0] FILL = 2'd0;
   localparam logic [1:0] PAD  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [1599:0] buf_q, buf_d;
   logic [1599:0] blk_q, blk_d;
   logic [7:0]    bptr_q, bptr_d;
   logic [1:0]    tid_q, tid_d;
   logic [1:0]    blk_tid_q, blk_tid_d;
   logic          first_pending_q, first_pending_d;
   logic          pad_pending_q, pad_pending_d;
   logic          blk_first_q, blk_first_d;
   logic          blk_last_q, blk_last_d;
   logic          blk_valid_q, blk_valid_d;

   logic          s_tready;
   logic          accept;
   logic          msg_start;
   logic [7:0]    rate_fill;
   logic [7:0]    rate_pad;
   logic [7:0]    n_bytes;
   logic [7:0]    bidx;
   logic          load_blk;

   // rate in bytes for each SHA3 output size
   function automatic logic [7:0] rate_of(input logic [1:0] t);
      case (t)
         2'd0:    return 8'd144;
         2'd1:    return 8'd136;
         2'd2:    return 8'd104;
         default: return 8'd72;
      endcase
   endfunction

   assign s_tready      = (state_q == FILL) & ~ARESET;
   assign accept        = bus.S_TVALID & s_tready;
   // the very first word of a message carries the TID; later words reuse the latched one
   assign msg_start     = first_pending_q & (bptr_q == 8'd0);
   assign rate_fill     = rate_of(msg_start ? bus.S_TID : tid_q);
   assign rate_pad      = rate_of(tid_q);

   assign bus.S_TREADY  = s_tready;
   assign bus.Blk       = blk_q;
   assign bus.Blk_tid   = blk_tid_q;
   assign bus.Blk_first = blk_first_q;
   assign bus.Blk_last  = blk_last_q;
   assign bus.Blk_valid = blk_valid_q;

   // next-state: byte packing, padding and block handoff
   always_comb begin
      state_d         = state_q;
      buf_d           = buf_q;
      blk_d           = blk_q;
      bptr_d          = bptr_q;
      tid_d           = tid_q;
      blk_tid_d       = blk_tid_q;
      first_pending_d = first_pending_q;
      pad_pending_d   = pad_pending_q;
      blk_first_d     = blk_first_q;
      blk_last_d      = blk_last_q;
      blk_valid_d     = blk_valid_q;
      load_blk        = 1'b0;
      n_bytes         = 8'(NB);
      bidx            = '0;

      case (state_q)
         FILL: begin
            if (accept) begin
               if (msg_start) tid_d = bus.S_TID;
               // the tail word contributes only its kept bytes
               if (bus.S_TLAST) begin
                  n_bytes = '0;
                  for (int i = 0; i < NB; i++) n_bytes = n_bytes + 8'(bus.S_TKEEP[i]);
               end
               for (int i = 0; i < NB; i++) begin
                  bidx = bptr_q + 8'(i);
                  if ((8'(i) < n_bytes) && bus.S_TKEEP[i])
                     buf_d[{bidx, 3'b000} +: 8] = bus.S_TDATA[i*8 +: 8];
               end
               bptr_d = bptr_q + n_bytes;
               if (bus.S_TLAST) begin
                  state_d = PAD;
               end else if (bptr_d >= rate_fill) begin
                  state_d    = HOLD;
                  blk_last_d = 1'b0;
                  load_blk   = 1'b1;
               end
            end
         end
         PAD: begin
            if (bptr_q >= rate_pad) begin
               // message ended exactly on a block boundary: padding goes in a block of its own
               pad_pending_d = 1'b1;
               blk_last_d    = 1'b0;
            end else begin
               buf_d[{bptr_q, 3'b000} +: 8]          = buf_q[{bptr_q, 3'b000} +: 8] | 8'h06;
               bidx                                  = rate_pad - 8'd1;
               buf_d[{bidx, 3'b000} +: 8]            = buf_d[{bidx, 3'b000} +: 8] | 8'h80;
               pad_pending_d = 1'b0;
               blk_last_d    = 1'b1;
            end
            state_d  = HOLD;
            load_blk = 1'b1;
         end
         HOLD: begin
            if (bus.Blk_ready) begin
               blk_valid_d     = 1'b0;
               buf_d           = '0;
               bptr_d          = '0;
               first_pending_d = blk_last_q;
               if (blk_last_q)         state_d = FILL;
               else if (pad_pending_q) state_d = PAD;
               else                    state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      if (load_blk) begin
         blk_d       = buf_d;
         blk_tid_d   = tid_d;
         blk_first_d = first_pending_q;
         blk_valid_d = 1'b1;
      end
   end

   // state registers, all cleared by async reset
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q         <= FILL;
         buf_q           <= '0;
         blk_q           <= '0;
         bptr_q          <= '0;
         tid_q           <= '0;
         blk_tid_q       <= '0;
         first_pending_q <= 1'b1;
         pad_pending_q   <= 1'b0;
         blk_first_q     <= 1'b0;
         blk_last_q      <= 1'b0;
         blk_valid_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         buf_q           <= buf_d;
         blk_q           <= blk_d;
         bptr_q          <= bptr_d;
         tid_q           <= tid_d;
         blk_tid_q       <= blk_tid_d;
         first_pending_q <= first_pending_d;
         pad_pending_q   <= pad_pending_d;
         blk_first_q     <= blk_first_d;
         blk_last_q      <= blk_last_d;
         blk_valid_q     <= blk_valid_d;
      end
   end
endmodule
